// File: rtl/smem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : smem_arbiter
// Purpose  : Round-robin arbiter/sequencer for the shared single-port RC4 S-memory
// Revision : 1.0  initial release
// ============================================================================
module smem_arbiter #(
   parameter int AW         = 8,
   parameter int DW         = 8,
   parameter int RD_LATENCY = 1,
   parameter int MAX_BURST  = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2:0]      req,
   input  logic [2:0]      req_wren,
   input  logic [3*AW-1:0] req_addr,
   input  logic [3*DW-1:0] req_data,
   output logic [2:0]      gnt,
   output logic [AW-1:0]   ram_address,
   output logic [DW-1:0]   ram_data,
   output logic            ram_wren,
   input  logic [DW-1:0]   ram_q,
   output logic [2:0]      rd_valid,
   output logic [DW-1:0]   rd_data
);

   localparam int            CW         = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
   localparam int            TD         = RD_LATENCY + 1;
   localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_OWN  = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      last_q, last_d;
   logic [CW-1:0]   burst_q, burst_d;
   logic [2:0]      gnt_q, gnt_d;

   logic [AW-1:0]   ram_address_q;
   logic [DW-1:0]   ram_data_q;
   logic            ram_wren_q;
   logic [TD-1:0]   tag_v_q;
   logic [1:0]      tag_k_q [TD];
   logic [2:0]      rd_valid_q;
   logic [DW-1:0]   rd_data_q;

   logic [1:0]      cand0, cand1, cand2, pick;
   logic            pick_vld;
   logic [2:0]      owner_oh;
   logic            accept, burst_last, others_wait;

   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   // last_q doubles as the current owner while in S_OWN
   assign owner_oh    = 3'b001 << last_q;
   assign accept      = (state_q == S_OWN) && req[last_q];
   assign burst_last  = (MAX_BURST != 0) && (burst_q == BURST_LAST);
   assign others_wait = |(req & ~owner_oh);

   always_comb begin
      cand0    = rr_next(last_q);
      cand1    = rr_next(cand0);
      cand2    = rr_next(cand1);
      pick     = cand0;
      pick_vld = 1'b1;
      if (req[cand0])      pick = cand0;
      else if (req[cand1]) pick = cand1;
      else if (req[cand2]) pick = cand2;
      else                 pick_vld = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      burst_d = burst_q;
      gnt_d   = gnt_q;
      if (state_q == S_IDLE) begin
         if (pick_vld) begin
            state_d = S_OWN;
            last_d  = pick;
            burst_d = '0;
            gnt_d   = 3'b001 << pick;
         end
      end else if (!accept) begin
         state_d = S_IDLE;
         gnt_d   = 3'b000;
      end else if (burst_last) begin
         burst_d = '0;
         if (others_wait) begin
            state_d = S_IDLE;
            gnt_d   = 3'b000;
         end
      end else begin
         burst_d = burst_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         last_q  <= 2'd2;
         burst_q <= '0;
         gnt_q   <= 3'b000;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         gnt_q   <= gnt_d;
      end
   end

   // Read tags ride a pipe independent of the grant so in-flight reads survive a handoff
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_address_q <= '0;
         ram_data_q    <= '0;
         ram_wren_q    <= 1'b0;
         tag_v_q       <= '0;
         for (int i = 0; i < TD; i++) tag_k_q[i] <= 2'd0;
         rd_valid_q    <= 3'b000;
         rd_data_q     <= '0;
      end else begin
         ram_wren_q <= 1'b0;
         if (accept) begin
            ram_address_q <= req_addr[last_q*AW +: AW];
            ram_data_q    <= req_data[last_q*DW +: DW];
            ram_wren_q    <= req_wren[last_q];
         end
         tag_v_q[0] <= accept && !req_wren[last_q];
         tag_k_q[0] <= last_q;
         for (int i = 1; i < TD; i++) begin
            tag_v_q[i] <= tag_v_q[i-1];
            tag_k_q[i] <= tag_k_q[i-1];
         end
         rd_valid_q <= tag_v_q[TD-1] ? (3'b001 << tag_k_q[TD-1]) : 3'b000;
         if (tag_v_q[TD-1]) rd_data_q <= ram_q;
      end
   end

   assign gnt         = gnt_q;
   assign ram_address = ram_address_q;
   assign ram_data    = ram_data_q;
   assign ram_wren    = ram_wren_q;
   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_data_q;

endmodule
`default_nettype wire

// File: doc/smem_arbiter.md
# smem_arbiter

Round-robin arbiter and sequencer for the single-port 256×8 S-memory shared by the RC4 engine's init loop, shuffle loop and decrypt loop. It grants the RAM port to one requester at a time and registers that requester's address, data and write enable onto the RAM. It returns read data tagged to the issuing requester and enforces a burst limit so no loop starves another. It replaces the loop-done-selected multiplexer on the RAM port.

## Interface
Parameters:
- `AW`, 8: address width.
- `DW`, 8: data width.
- `RD_LATENCY`, 1: RAM read latency in cycles from the address-sampling edge to valid `ram_q`. Legal values are 1 and 2.
- `MAX_BURST`, 64: maximum accesses per grant while another requester waits. A value of 0 means unlimited.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req`, input, 3: per-requester request. Index 0 is init, 1 is shuffle, 2 is decrypt.
- `req_wren`, input, 3: per-requester write enable.
- `req_addr`, input, 3*AW: packed addresses. Requester k uses bits [k*AW +: AW].
- `req_data`, input, 3*DW: packed write data.
- `gnt`, output, 3: one-hot or zero grant, registered.
- `ram_address`, output, AW: RAM address, registered.
- `ram_data`, output, DW: RAM write data, registered.
- `ram_wren`, output, 1: RAM write enable, registered.
- `ram_q`, input, DW: RAM read data.
- `rd_valid`, output, 3: one-cycle pulse per requester when `rd_data` holds its read result.
- `rd_data`, output, DW: registered read data.

## Operation
- States:
  - IDLE: `gnt`=0.
  - OWN: `gnt[owner]`=1.
- IDLE → OWN: at an edge where any `req` bit is high. The owner is the first requester with `req` high, searching from `last_owner+1` mod 3. `last_owner` becomes that requester and the burst count clears.
- Accepted access: at edge E0, `gnt[k]`=1 and `req[k]`=1. The requester's addr, data and wren are registered onto `ram_*` at E0 and the burst count increments.
- No access: at an edge with no accepted access, `ram_wren` is cleared to 0. `ram_address` and `ram_data` hold their values.
- OWN → IDLE when either condition holds:
  - `req[owner]`=0 at an edge. No access is accepted at that edge.
  - `MAX_BURST`≠0, the access accepted at this edge brings the count to `MAX_BURST`, and another `req` bit is high. That access is still performed.
- Count reaches `MAX_BURST` with no other requester waiting: the count clears and the grant continues.
- There is always at least one IDLE cycle with `gnt`=0 between grants.
- A requester whose grant is revoked keeps `req` high and regains the port in round-robin order. It must not change its addr, data or wren while `gnt`=0.
- Read tagging: each accepted access with wren=0 enters a tag pipeline of depth `RD_LATENCY`+1 holding {valid, k}.
  - `rd_data` ← `ram_q` and `rd_valid[k]` ← 1 at edge E0+`RD_LATENCY`+1, for one cycle.
  - Writes produce no `rd_valid`.
- In-flight reads complete normally after the grant moves to another requester. Their tags are independent of `gnt`.
- Reset, asynchronous at any time:
  - Outputs: `gnt`=0, `ram_wren`=0, `ram_address`=0, `ram_data`=0, `rd_valid`=0, `rd_data`=0.
  - Internal: state IDLE, burst count 0, `last_owner`=2 (so requester 0 wins first), tag pipeline cleared.
  - Reads in flight at reset never produce `rd_valid`.

## Timing
- Request to grant: `req[k]` rising before edge E leads to `gnt[k]` high after E, when the arbiter is IDLE and k wins. Minimum latency is 1 cycle.
- Grant to first access: the first accepted access is at edge E+1. `ram_*` reflect it after E+1.
- Back-to-back accesses are accepted every cycle while owned. Throughput is 1 access per cycle.
- Read latency, acceptance edge to `rd_valid`: `RD_LATENCY`+1 edges. For `RD_LATENCY`=1 this is 2 cycles.
- Release: `req[owner]` low at edge R gives `gnt`=0 after R. The next grant is asserted after R+1 at the earliest.
- Burst revoke: the `MAX_BURST`-th access at edge B gives `gnt`=0 after B. The new owner is granted after B+1.
- Simultaneous rise of all three `req` bits from reset: grant order is 0, then 1, then 2.

## Test plan
- Single read, requester 0:
  - Stimulus: `RD_LATENCY`=1; `req[0]`=1, addr=0x3C, wren=0; RAM holds 0xA5 at 0x3C.
  - Response: `gnt[0]` after edge 1; `ram_address`=0x3C after edge 2; `rd_valid[0]`=1 and `rd_data`=0xA5 after edge 4, for exactly one cycle.
- Init loop writes:
  - Stimulus: requester 0 writes addr i, data i for i=0..255 with `MAX_BURST`=0.
  - Response: 256 consecutive cycles with `ram_wren`=1, no gaps; final readback of 0xFF gives 0xFF.
- Contention:
  - Stimulus: `req`=3'b111 from reset; each requester holds req for 4 accesses, then drops it.
  - Response: grant order 0→1→2; exactly one `gnt`=0 cycle between owners; 12 accesses total.
- Burst limit:
  - Stimulus: `MAX_BURST`=4; `req[1]` held continuously; `req[2]` raised after requester 1's first access.
  - Response: requester 1 gets exactly 4 accesses; `gnt`=0 for one cycle; `gnt[2]` follows. Requester 1 alone with `MAX_BURST`=4: grant never drops.
- Read across handoff:
  - Stimulus: requester 1 issues a read on its last accepted cycle, then drops `req`; requester 2 is waiting.
  - Response: `rd_valid[1]` pulses with the correct data while `gnt[2]` is high; `rd_valid[2]` does not pulse.
- Reset mid-read:
  - Stimulus: assert `rst_n`=0 one cycle after a read is accepted.
  - Response: all outputs are 0 immediately; no `rd_valid` after reset releases; the first grant after reset goes to requester 0.
